// File: rtl/dht11_sensor_emu_pkg.sv
// Shared definitions for the DHT11 sensor emulator and the host-side reader.
// Holds the FSM state encoding, the default protocol timing in microseconds,
// and the frame checksum helper.
package dht11_sensor_emu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLowMeas,
        StRespWait,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StEndLow
    } state_t;

    // Default protocol timing, all in microseconds.
    localparam int unsigned DefClkPerUs   = 50;
    localparam int unsigned DefStartMinUs = 18000;
    localparam int unsigned DefRespDelayUs = 30;
    localparam int unsigned DefRespLowUs  = 80;
    localparam int unsigned DefRespHighUs = 80;
    localparam int unsigned DefBitLowUs   = 50;
    localparam int unsigned DefBit0HighUs = 26;
    localparam int unsigned DefBit1HighUs = 70;

    localparam int unsigned FrameBits = 40;

    // Byte sum is carried in 10 bits and truncated to 8; optional LSB flip
    // produces a deliberately bad checksum.
    function automatic logic [7:0] frame_csum(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c,
                                              input logic [7:0] d,
                                              input logic       corrupt);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return 8'(sum) ^ {7'b0000000, corrupt};
    endfunction

endpackage

// File: rtl/dht11_sensor_emu_us_timer.sv
// Microsecond timebase: a prescaler counting 0..CLK_PER_US-1 and a 15-bit
// saturating microsecond counter.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : restart both prescaler and counter from zero
//   tick  : high on the prescaler terminal count (last cycle of each us)
//   count : whole microseconds elapsed since the last clear, saturating
module us_timer #(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    output logic        tick,
    output logic [14:0] count
);

    localparam int unsigned PreW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PreW-1:0] PreTerm = PreW'(CLK_PER_US - 1);

    logic [PreW-1:0] presc_q;
    logic [14:0]     count_q;

    // Tick depends only on registered state so the FSM's clear (derived from
    // next-state) never forms a combinational loop through it.
    assign tick  = (presc_q == PreTerm);
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
            if (count_q != 15'h7fff) begin
                count_q <= count_q + 15'd1;
            end
        end else begin
            presc_q <= presc_q + PreW'(1);
        end
    end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: device end of the single-wire DHT11 protocol.
// Detects a host start pulse, then answers with the response preamble and a
// 40-bit frame {hum_int, hum_dec, tmp_int, tmp_dec, csum}, MSB first.
//   clk, rst            : system clock, synchronous active-high reset
//   dq_in               : raw (asynchronous) data-line level
//   dq_oe               : 1 = pull the line low, 0 = release
//   hum_*, tmp_*        : reading latched at start acceptance
//   bad_csum            : flip checksum LSB for the frame being latched
//   busy                : high from accepted start until frame end
//   frame_done          : one-cycle pulse when a frame completes
module dht11_sensor_emu
    import dht11_sensor_emu_pkg::*;
#(
    parameter int unsigned CLK_PER_US    = DefClkPerUs,
    parameter int unsigned START_MIN_US  = DefStartMinUs,
    parameter int unsigned RESP_DELAY_US = DefRespDelayUs,
    parameter int unsigned RESP_LOW_US   = DefRespLowUs,
    parameter int unsigned RESP_HIGH_US  = DefRespHighUs,
    parameter int unsigned BIT_LOW_US    = DefBitLowUs,
    parameter int unsigned BIT0_HIGH_US  = DefBit0HighUs,
    parameter int unsigned BIT1_HIGH_US  = DefBit1HighUs
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dq_in,
    output logic       dq_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       bad_csum,
    output logic       busy,
    output logic       frame_done
);

    logic        dq_meta, dq_s, dq_prev;
    state_t      state_q, state_d;
    logic        tmr_clear, tmr_tick;
    logic [14:0] tmr_count;
    logic [14:0] phase_len;
    logic        phase_done, start_ok, latch, shift_en;
    logic [39:0] shift_q;
    logic [5:0]  bit_cnt_q;
    logic        dq_oe_d, busy_d, frame_done_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    // Reset to the idle-high bus level so reset itself never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            dq_meta <= 1'b1;
            dq_s    <= 1'b1;
            dq_prev <= 1'b1;
        end else begin
            dq_meta <= dq_in;
            dq_s    <= dq_meta;
            dq_prev <= dq_s;
        end
    end

    // Every state entry restarts the timebase.
    assign tmr_clear = (state_d != state_q);

    us_timer #(
        .CLK_PER_US(CLK_PER_US)
    ) u_us_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(tmr_clear),
        .tick (tmr_tick),
        .count(tmr_count)
    );

    always_comb begin
        phase_len = 15'd1;
        case (state_q)
            StRespWait: phase_len = 15'(RESP_DELAY_US);
            StRespLow:  phase_len = 15'(RESP_LOW_US);
            StRespHigh: phase_len = 15'(RESP_HIGH_US);
            StBitLow:   phase_len = 15'(BIT_LOW_US);
            StBitHigh:  phase_len = shift_q[39] ? 15'(BIT1_HIGH_US) : 15'(BIT0_HIGH_US);
            StEndLow:   phase_len = 15'(BIT_LOW_US);
            default:    phase_len = 15'd1;
        endcase
    end

    // Phase ends on the last cycle of its final microsecond, so an N us phase
    // occupies exactly N * CLK_PER_US cycles.
    assign phase_done = tmr_tick && (tmr_count == phase_len - 15'd1);
    assign start_ok   = (tmr_count >= 15'(START_MIN_US));
    assign latch      = (state_q == StLowMeas) && dq_s && start_ok;
    assign shift_en   = (state_q == StBitHigh) && phase_done;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dq_oe      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            dq_oe      <= dq_oe_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Only a fresh high-to-low edge starts a measurement, so our own
            // END_LOW drive draining through the synchronizer is not a start.
            StIdle:     if (!dq_s && dq_prev) state_d = StLowMeas;
            StLowMeas:  if (dq_s) state_d = start_ok ? StRespWait : StIdle;
            StRespWait: if (phase_done) state_d = StRespLow;
            StRespLow:  if (phase_done) state_d = StRespHigh;
            StRespHigh: if (phase_done) state_d = StBitLow;
            StBitLow:   if (phase_done) state_d = StBitHigh;
            StBitHigh:  if (phase_done) state_d = (bit_cnt_q == 6'd1) ? StEndLow : StBitLow;
            StEndLow:   if (phase_done) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output decode from next-state, registered above.
    always_comb begin
        dq_oe_d      = (state_d == StRespLow) || (state_d == StBitLow) ||
                       (state_d == StEndLow);
        busy_d       = (state_d != StIdle) && (state_d != StLowMeas);
        frame_done_d = (state_q == StEndLow) && (state_d == StIdle);
    end

    // Frame shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (latch) begin
            shift_q   <= {hum_int, hum_dec, tmp_int, tmp_dec,
                          frame_csum(hum_int, hum_dec, tmp_int, tmp_dec, bad_csum)};
            bit_cnt_q <= 6'(FrameBits);
        end else if (shift_en) begin
            shift_q   <= {shift_q[38:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - 6'd1;
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
module tb_dht11_sensor_emu;

    localparam int unsigned ClkPerUs   = 1;
    localparam int unsigned StartMinUs = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic       dq_in;
    logic       dq_oe;
    logic [7:0] hum_int = 8'h00;
    logic [7:0] hum_dec = 8'h00;
    logic [7:0] tmp_int = 8'h00;
    logic [7:0] tmp_dec = 8'h00;
    logic       bad_csum = 1'b0;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Open-drain wire with pull-up: low if either end drives.
    assign dq_in = ~(host_low | dq_oe);

    always #5 clk = ~clk;

    dht11_sensor_emu #(
        .CLK_PER_US  (ClkPerUs),
        .START_MIN_US(StartMinUs)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dq_in     (dq_in),
        .dq_oe     (dq_oe),
        .hum_int   (hum_int),
        .hum_dec   (hum_dec),
        .tmp_int   (tmp_int),
        .tmp_dec   (tmp_dec),
        .bad_csum  (bad_csum),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: four data bytes then their byte sum mod 256,
    // LSB inverted when a bad checksum is requested.
    function automatic logic [39:0] ref_frame(input logic [7:0] h, input logic [7:0] hd,
                                              input logic [7:0] t, input logic [7:0] td,
                                              input logic bad);
        int s;
        logic [7:0] cs;
        s  = (int'(h) + int'(hd) + int'(t) + int'(td)) % 256;
        if (bad) s = s ^ 1;
        cs = 8'(s);
        return {h, hd, t, td, cs};
    endfunction

    function automatic int high_us(input logic b);
        return b ? 70 : 26;
    endfunction

    // Host start pulse: pull low for 'us' cycles, release just after a posedge.
    task automatic host_start(input int us);
        @(posedge clk);
        #1 host_low = 1'b1;
        repeat (us) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    task automatic set_inputs(input logic [7:0] h, input logic [7:0] hd, input logic [7:0] t,
                              input logic [7:0] td, input logic bad);
        hum_int  = h;
        hum_dec  = hd;
        tmp_int  = t;
        tmp_dec  = td;
        bad_csum = bad;
    endtask

    // Full transaction: start pulse, then record dq_oe as run lengths (one
    // sample per us) and decode the frame from pulse widths.
    task automatic run_frame(input string tag, input int low_us, input logic [7:0] h,
                             input logic [7:0] hd, input logic [7:0] t, input logic [7:0] td,
                             input logic bad, input bit change_mid);
        logic [39:0] exp;
        logic [39:0] got;
        int          runs[$];
        int          run_len, idx, hi_sum, bad_slots;
        logic        cur;
        bit          done;

        set_inputs(h, hd, t, td, bad);
        exp    = ref_frame(h, hd, t, td, bad);
        hi_sum = 0;
        for (int b = 0; b < 40; b++) hi_sum += high_us(exp[b]);

        host_start(low_us);
        cur = 1'b0; run_len = 0; idx = 0; done = 1'b0;
        while (!done && idx < 6000) begin
            @(negedge clk);
            if (idx == 2) check_eq({tag, ".busy_pre"}, 64'(busy), 64'd0);
            if (idx == 3) check_eq({tag, ".busy_on"}, 64'(busy), 64'd1);
            if (change_mid && idx == 10) set_inputs(8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0);
            if (dq_oe !== cur) begin
                runs.push_back(run_len);
                cur     = dq_oe;
                run_len = 1;
            end else begin
                run_len++;
            end
            if (frame_done === 1'b1) begin
                done = 1'b1;
                check_eq({tag, ".done_time"}, 64'(idx), 64'(3 + 2240 + hi_sum));
                check_eq({tag, ".busy_end"}, 64'(busy), 64'd0);
                check_eq({tag, ".oe_end"}, 64'(dq_oe), 64'd0);
            end
            idx++;
        end
        check_eq({tag, ".done_seen"}, 64'(done), 64'd1);
        check_eq({tag, ".pulse_count"}, 64'(runs.size()), 64'd84);
        if (runs.size() >= 84) begin
            check_eq({tag, ".resp_delay"}, 64'(runs[0]), 64'd33);
            check_eq({tag, ".resp_low"}, 64'(runs[1]), 64'd80);
            check_eq({tag, ".resp_high"}, 64'(runs[2]), 64'd80);
            bad_slots = 0;
            got       = '0;
            for (int b = 0; b < 40; b++) begin
                got[39-b] = (runs[4+2*b] > 48);
                if (runs[3+2*b] != 50 || runs[4+2*b] != high_us(exp[39-b])) bad_slots++;
            end
            check_eq({tag, ".slot_errs"}, 64'(bad_slots), 64'd0);
            check_eq({tag, ".frame"}, 64'(got), 64'(exp));
            check_eq({tag, ".end_low"}, 64'(runs[83]), 64'd50);
        end
        @(negedge clk);
        check_eq({tag, ".done_1cyc"}, 64'(frame_done), 64'd0);
        repeat (20) @(posedge clk);
    endtask

    // Short low pulse: no response may appear.
    task automatic run_reject(input string tag, input int low_us);
        int activity;
        host_start(low_us);
        activity = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dq_oe !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) activity++;
        end
        check_eq({tag, ".quiet"}, 64'(activity), 64'd0);
    endtask

    // Reset issued in the low slot of bit 12 (counting from 0).
    task automatic run_reset(input string tag, input logic [7:0] h, input logic [7:0] hd,
                             input logic [7:0] t, input logic [7:0] td);
        logic [39:0] exp;
        int          target, activity;
        set_inputs(h, hd, t, td, 1'b0);
        exp    = ref_frame(h, hd, t, td, 1'b0);
        target = 33 + 80 + 80 + 20;
        for (int b = 0; b < 12; b++) target += 50 + high_us(exp[39-b]);
        host_start(150);
        for (int i = 0; i <= target; i++) @(negedge clk);
        check_eq({tag, ".in_bit12"}, 64'(dq_oe), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, ".oe_rel"}, 64'(dq_oe), 64'd0);
        check_eq({tag, ".busy_rel"}, 64'(busy), 64'd0);
        rst = 1'b0;
        activity = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || dq_oe !== 1'b0 || busy !== 1'b0) activity++;
        end
        check_eq({tag, ".no_done"}, 64'(activity), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.dq_oe", 64'(dq_oe), 64'd0);
        check_eq("reset.busy", 64'(busy), 64'd0);
        check_eq("reset.frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        run_frame("basic", 150, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b0);
        run_reject("short60", 60);
        run_reject("short95", 95);
        run_frame("badcsum", 150, 8'h37, 8'h00, 8'h19, 8'h05, 1'b1, 1'b0);
        run_frame("wrap", 130, 8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0, 1'b0);
        run_reset("rst", 8'h5A, 8'hC3, 8'h21, 8'h7E);
        run_frame("after_rst", 150, 8'h5A, 8'hC3, 8'h21, 8'h7E, 1'b0, 1'b0);
        run_frame("midchg", 120, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b1);
        run_frame("next_aa", 120, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("rnd%0d", i), int'($urandom_range(200, 110)),
                      8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom_range(1, 0)), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            run_reject($sformatf("rnd_short%0d", i), int'($urandom_range(95, 5)));
        end
        run_frame("final", 150, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
